// File: rtl/encoder32to5_q.sv
// Queued 32-to-5 priority encoder: sticky pending events
// issued highest-index-first over a valid/ready handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      32 event strobes, each sets its pending bit
//   en       issue enable (intake continues while low)
//   clr      synchronous flush of pending and output stage
//   ready    consumer accepts idx when valid is high
//   idx      5-bit index of the issued request
//   valid    idx holds an unaccepted index
//   pending  current pending register
//   busy     valid or any pending bit
module encoder32to5_q (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    input  logic        en,
    input  logic        clr,
    input  logic        ready,
    output logic [4:0]  idx,
    output logic        valid,
    output logic [31:0] pending,
    output logic        busy
);

    logic        any_pend;
    logic        slot_free;
    logic        load;
    logic [4:0]  sel;
    logic [31:0] take_mask;
    logic [31:0] pend_nxt;
    logic        valid_nxt;
    logic [4:0]  idx_nxt;

    assign any_pend  = |pending;
    assign slot_free = ~valid | ready;
    assign load      = en & ~clr & any_pend & slot_free;

    // Ascending scan: the last hit, i.e. the highest
    // set bit, wins. Only the registered pending is
    // eligible, so a req this cycle waits an edge.
    always_comb begin
        sel = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (pending[i]) begin
                sel = i[4:0];
            end
        end
    end

    always_comb begin
        take_mask = 32'd0;
        if (load) begin
            take_mask[sel] = 1'b1;
        end
    end

    // OR-ing req after the clear keeps a new event
    // that lands on the bit being issued this edge.
    always_comb begin
        pend_nxt  = (pending & ~take_mask) | req;
        valid_nxt = valid;
        idx_nxt   = idx;
        if (clr) begin
            pend_nxt  = 32'd0;
            valid_nxt = 1'b0;
        end else if (load) begin
            valid_nxt = 1'b1;
            idx_nxt   = sel;
        end else if (valid && ready) begin
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 32'd0;
            valid   <= 1'b0;
            idx     <= 5'd0;
        end else begin
            pending <= pend_nxt;
            valid   <= valid_nxt;
            idx     <= idx_nxt;
        end
    end

    assign busy = valid | any_pend;

endmodule

// File: tb/tb_encoder32to5_q.sv
// Directed self-checking bench for encoder32to5_q.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_encoder32to5_q;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic        en;
    logic        clr;
    logic        ready;
    logic [4:0]  idx;
    logic        valid;
    logic [31:0] pending;
    logic        busy;

    int n_cmp;
    int n_err;

    encoder32to5_q dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .en      (en),
        .clr     (clr),
        .ready   (ready),
        .idx     (idx),
        .valid   (valid),
        .pending (pending),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        en    = 1'b0;
        clr   = 1'b0;
        ready = 1'b0;
        #3;
        n_cmp++;
        if (pending !== 32'd0 || valid !== 1'b0 ||
            busy !== 1'b0 || idx !== 5'd0) begin
            n_err++;
            $display("FAIL reset_init: pend=%h v=%b b=%b idx=%0d want 0/0/0/0",
                     pending, valid, busy, idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // build a burst: all lines pending, output stalled
        req   = 32'hFFFF_FFFF;
        en    = 1'b1;
        ready = 1'b0;
        tick();
        tick();
        req = '0;
        n_cmp++;
        if (pending !== 32'hFFFF_FFFF || valid !== 1'b1 ||
            idx !== 5'd31) begin
            n_err++;
            $display("FAIL burst_setup: pend=%h v=%b idx=%0d want ffffffff/1/31",
                     pending, valid, idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pending !== 32'd0) begin
            n_err++;
            $display("FAIL rst_pending: got %h want 0", pending);
        end
        n_cmp++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_valid: got %b want 0", valid);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rst_release_%0d: v=%b b=%b want 0/0",
                         i, valid, busy);
            end
        end
    endtask

    task automatic test_priority_drain();
        logic [4:0] exp_idx [4];
        exp_idx = '{5'd31, 5'd10, 5'd5, 5'd0};
        en    = 1'b1;
        ready = 1'b1;
        req   = 32'h8000_0421;
        tick();
        req = '0;
        n_cmp++;
        if (pending !== 32'h8000_0421 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_intake: pend=%h v=%b want 80000421/0",
                     pending, valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (valid !== 1'b1 || idx !== exp_idx[i]) begin
                n_err++;
                $display("FAIL drain_%0d: v=%b idx=%0d want 1/%0d",
                         i, valid, idx, exp_idx[i]);
            end
        end
        tick();
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drain_end: v=%b b=%b want 0/0", valid, busy);
        end
    endtask

    task automatic test_backpressure();
        en    = 1'b1;
        ready = 1'b0;
        req   = 32'h0000_0006;
        tick();
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (valid !== 1'b1 || idx !== 5'd2 ||
                pending !== 32'h0000_0002) begin
                n_err++;
                $display("FAIL stall_%0d: v=%b idx=%0d pend=%h want 1/2/00000002",
                         i, valid, idx, pending);
            end
        end
        ready = 1'b1;
        tick();
        n_cmp++;
        if (valid !== 1'b1 || idx !== 5'd1) begin
            n_err++;
            $display("FAIL stall_next: v=%b idx=%0d want 1/1", valid, idx);
        end
        tick();
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stall_end: v=%b b=%b want 0/0", valid, busy);
        end
    endtask

    task automatic test_set_beats_clear();
        int issued;
        issued = 0;
        en     = 1'b1;
        ready  = 1'b1;
        req    = 32'h0000_0080;
        tick();
        // req[7] again on the edge where 7 is loaded
        tick();
        req = '0;
        n_cmp++;
        if (valid !== 1'b1 || idx !== 5'd7 || pending[7] !== 1'b1) begin
            n_err++;
            $display("FAIL sbc_load: v=%b idx=%0d p7=%b want 1/7/1",
                     valid, idx, pending[7]);
        end
        if (valid === 1'b1 && idx === 5'd7) issued++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid === 1'b1 && idx === 5'd7) issued++;
        end
        n_cmp++;
        if (issued != 2) begin
            n_err++;
            $display("FAIL sbc_count: got %0d issues want 2", issued);
        end
        n_cmp++;
        if (pending[7] !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL sbc_after: p7=%b b=%b want 0/0",
                     pending[7], busy);
        end
    endtask

    task automatic test_stall_flush();
        int issued;
        issued = 0;
        en     = 1'b0;
        ready  = 1'b1;
        req    = 32'h0001_0000;
        tick();
        req = '0;
        tick();
        n_cmp++;
        if (pending !== 32'h0001_0000 || valid !== 1'b0 ||
            busy !== 1'b1) begin
            n_err++;
            $display("FAIL en_low: pend=%h v=%b b=%b want 00010000/0/1",
                     pending, valid, busy);
        end
        clr = 1'b1;
        req = 32'h0000_0001;
        tick();
        clr = 1'b0;
        req = '0;
        n_cmp++;
        if (pending !== 32'd0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL clr: pend=%h v=%b want 0/0", pending, valid);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid === 1'b1) issued++;
        end
        n_cmp++;
        if (issued != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL clr_after: issued=%0d b=%b want 0/0",
                     issued, busy);
        end
    endtask

    task automatic test_merge();
        int issued;
        issued = 0;
        en     = 1'b0;
        ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req = 32'h0000_0008;
            tick();
            req = '0;
            tick();
        end
        n_cmp++;
        if (pending !== 32'h0000_0008 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL merge_pend: pend=%h v=%b want 00000008/0",
                     pending, valid);
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid === 1'b1 && idx === 5'd3) issued++;
        end
        n_cmp++;
        if (issued != 1) begin
            n_err++;
            $display("FAIL merge_count: got %0d issues want 1", issued);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_priority_drain();
        test_backpressure();
        test_set_beats_clear();
        test_stall_flush();
        test_merge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
